// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline datapath and its hazard/sequencing controller.
// The master modport is the datapath side; the slave modport is the controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_Rn;
  logic [4:0]       ID_Rm;
  logic             ID_useRn;
  logic             ID_useRm;
  logic             ID_BrTaken;
  logic [4:0]       EX_Rd;
  logic             EX_MemRead;
  logic             MEM_MemRead;
  logic             MEM_MemWrite;
  logic             dmem_ack;
  logic             dmem_req;
  logic             pc_we;
  logic             IFID_we;
  logic             IFID_flush;
  logic             IDEX_bubble;
  logic             EXMEM_we;
  logic             MEMWB_we;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic [1:0]       dbg_state;

  modport master (
    output ID_Rn, ID_Rm, ID_useRn, ID_useRm, ID_BrTaken,
    output EX_Rd, EX_MemRead, MEM_MemRead, MEM_MemWrite, dmem_ack,
    input  dmem_req, pc_we, IFID_we, IFID_flush, IDEX_bubble, EXMEM_we, MEMWB_we,
    input  timeout_err, stall_cycles, flush_count, dbg_state
  );

  modport slave (
    input  ID_Rn, ID_Rm, ID_useRn, ID_useRm, ID_BrTaken,
    input  EX_Rd, EX_MemRead, MEM_MemRead, MEM_MemWrite, dmem_ack,
    output dmem_req, pc_we, IFID_we, IFID_flush, IDEX_bubble, EXMEM_we, MEMWB_we,
    output timeout_err, stall_cycles, flush_count, dbg_state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use bubble, taken-branch flush and data-memory freeze/timeout controller for the
// 5-stage pipeline, with saturating stall and flush counters. dbg_state: 0 RUN, 1 MEM_WAIT, 2 ERR.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic mem_op;
  logic lu;
  logic dmem_req_c, pc_we_c, ifid_we_c, ifid_flush_c, idex_bubble_c;
  logic exmem_we_c, memwb_we_c, timeout_err_c;

  assign mem_op = bus.MEM_MemRead | bus.MEM_MemWrite;

  // XZR as a load destination never produces a hazard.
  assign lu = bus.EX_MemRead && (bus.EX_Rd != 5'd31) &&
              ((bus.ID_useRn && (bus.EX_Rd == bus.ID_Rn)) ||
               (bus.ID_useRm && (bus.EX_Rd == bus.ID_Rm)));

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    dmem_req_c    = 1'b0;
    pc_we_c       = 1'b0;
    ifid_we_c     = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    exmem_we_c    = 1'b0;
    memwb_we_c    = 1'b0;
    timeout_err_c = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        dmem_req_c = mem_op;
        if (mem_op && !bus.dmem_ack) begin
          state_d = ST_MEM_WAIT;
          wcnt_d  = WCNT_W'(1);
        end else if (lu) begin
          // Branch operand is not valid yet, so a taken branch waits for the bubble.
          idex_bubble_c = 1'b1;
          exmem_we_c    = 1'b1;
          memwb_we_c    = 1'b1;
        end else begin
          pc_we_c      = 1'b1;
          ifid_we_c    = 1'b1;
          exmem_we_c   = 1'b1;
          memwb_we_c   = 1'b1;
          ifid_flush_c = bus.ID_BrTaken;
        end
      end

      ST_MEM_WAIT: begin
        dmem_req_c = 1'b1;
        if (bus.dmem_ack) begin
          // Release cycle: the hazard checks run as in RUN; ack beats the timeout.
          state_d    = ST_RUN;
          exmem_we_c = 1'b1;
          memwb_we_c = 1'b1;
          if (lu) begin
            idex_bubble_c = 1'b1;
          end else begin
            pc_we_c      = 1'b1;
            ifid_we_c    = 1'b1;
            ifid_flush_c = bus.ID_BrTaken;
          end
        end else if (wcnt_q == WCNT_W'(MEM_TIMEOUT)) begin
          state_d = ST_ERR;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end

      ST_ERR: begin
        timeout_err_c = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (reset) begin
      dmem_req_c    = 1'b0;
      pc_we_c       = 1'b0;
      ifid_we_c     = 1'b0;
      ifid_flush_c  = 1'b0;
      idex_bubble_c = 1'b0;
      exmem_we_c    = 1'b0;
      memwb_we_c    = 1'b0;
      timeout_err_c = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_we_c && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
    if (ifid_flush_c && (flush_q != {CNT_W{1'b1}})) begin
      flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      wcnt_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.dmem_req     = dmem_req_c;
  assign bus.pc_we        = pc_we_c;
  assign bus.IFID_we      = ifid_we_c;
  assign bus.IFID_flush   = ifid_flush_c;
  assign bus.IDEX_bubble  = idex_bubble_c;
  assign bus.EXMEM_we     = exmem_we_c;
  assign bus.MEMWB_we     = memwb_we_c;
  assign bus.timeout_err  = timeout_err_c;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4 and CNT_W=3.
// Control outputs are packed {dmem_req,pc_we,IFID_we,IFID_flush,IDEX_bubble,EXMEM_we,MEMWB_we,timeout_err}.
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 3;

  localparam logic [7:0] O_RST    = 8'h00;
  localparam logic [7:0] O_NORM   = 8'h66;
  localparam logic [7:0] O_LU     = 8'h0E;
  localparam logic [7:0] O_BR     = 8'h76;
  localparam logic [7:0] O_FRZ    = 8'h80;
  localparam logic [7:0] O_MEM_OK = 8'hE6;
  localparam logic [7:0] O_MEM_LU = 8'h8E;
  localparam logic [7:0] O_ERR    = 8'h01;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   exp_stall;
  int   exp_flush;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  wire [7:0] outs = {bus.dmem_req, bus.pc_we, bus.IFID_we, bus.IFID_flush,
                     bus.IDEX_bubble, bus.EXMEM_we, bus.MEMWB_we, bus.timeout_err};

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks; inputs change on the falling edge.
  task automatic set_idle();
    bus.ID_Rn        = 5'd0;
    bus.ID_Rm        = 5'd0;
    bus.ID_useRn     = 1'b0;
    bus.ID_useRm     = 1'b0;
    bus.ID_BrTaken   = 1'b0;
    bus.EX_Rd        = 5'd0;
    bus.EX_MemRead   = 1'b0;
    bus.MEM_MemRead  = 1'b0;
    bus.MEM_MemWrite = 1'b0;
    bus.dmem_ack     = 1'b0;
  endtask

  task automatic drive_hazard(input logic [4:0] ex_rd, input logic ex_ld,
                              input logic [4:0] rn, input logic use_rn,
                              input logic [4:0] rm, input logic use_rm, input logic br);
    bus.EX_Rd      = ex_rd;
    bus.EX_MemRead = ex_ld;
    bus.ID_Rn      = rn;
    bus.ID_useRn   = use_rn;
    bus.ID_Rm      = rm;
    bus.ID_useRm   = use_rm;
    bus.ID_BrTaken = br;
  endtask

  task automatic drive_mem(input logic rd, input logic wr, input logic ack);
    bus.MEM_MemRead  = rd;
    bus.MEM_MemWrite = wr;
    bus.dmem_ack     = ack;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    set_idle();
    #1;
    check("rst_outs", 32'(outs), 32'(O_RST));
    check("rst_stall", 32'(bus.stall_cycles), 0);
    check("rst_flush", 32'(bus.flush_count), 0);
    check("rst_state", 32'(bus.dbg_state), 0);
    next_cycle();
    reset     = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
  endtask

  // Check combinational outputs a moment after the inputs settle, then clock once.
  task automatic cycle_check(input string tag, input logic [7:0] exp_outs);
    #1;
    check(tag, 32'(outs), 32'(exp_outs));
    if (!exp_outs[6]) exp_stall++;
    if (exp_outs[4])  exp_flush++;
    next_cycle();
    check({tag, "_stall"}, 32'(bus.stall_cycles), 32'(exp_stall > 7 ? 7 : exp_stall));
    check({tag, "_flush"}, 32'(bus.flush_count), 32'(exp_flush > 7 ? 7 : exp_flush));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_stall = 0;
    exp_flush = 0;
    reset     = 1'b1;
    set_idle();
    next_cycle();
    apply_reset();

    // Load-use with a zero-wait memory access in the same cycle.
    drive_hazard(5'd1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0);
    drive_mem(1'b1, 1'b0, 1'b1);
    cycle_check("lu_rn_ack", O_MEM_LU);
    set_idle();
    cycle_check("idle", O_NORM);
    drive_hazard(5'd7, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0);
    cycle_check("lu_rm", O_LU);
    drive_hazard(5'd7, 1'b1, 5'd7, 1'b0, 5'd3, 1'b1, 1'b0);
    cycle_check("no_use_rn", O_NORM);
    drive_hazard(5'd7, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0);
    cycle_check("not_load", O_NORM);

    // XZR never hazards.
    drive_hazard(5'd31, 1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 1'b0);
    cycle_check("xzr", O_NORM);

    // Taken branch, then taken branch shadowed by a load-use.
    drive_hazard(5'd2, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b1);
    cycle_check("branch", O_BR);
    drive_hazard(5'd2, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b1);
    cycle_check("branch_lu", O_LU);

    // Three wait cycles then ack; store with zero wait afterwards.
    apply_reset();
    drive_mem(1'b1, 1'b0, 1'b0);
    cycle_check("wait1", O_FRZ);
    check("wait_state", 32'(bus.dbg_state), 1);
    cycle_check("wait2", O_FRZ);
    cycle_check("wait3", O_FRZ);
    drive_mem(1'b1, 1'b0, 1'b1);
    drive_hazard(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    cycle_check("wait_ack_br", O_MEM_OK | 8'h10);
    check("wait_back_run", 32'(bus.dbg_state), 0);
    set_idle();
    drive_mem(1'b0, 1'b1, 1'b1);
    cycle_check("store_ack", O_MEM_OK);

    // Ack arriving exactly when wcnt hits the timeout wins, with a load-use on release.
    apply_reset();
    drive_mem(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < MEM_TIMEOUT; i++) cycle_check("edge_wait", O_FRZ);
    drive_mem(1'b0, 1'b1, 1'b1);
    drive_hazard(5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
    cycle_check("edge_ack_lu", O_MEM_LU);
    check("edge_state", 32'(bus.dbg_state), 0);

    // Timeout: no ack at all.
    apply_reset();
    drive_mem(1'b1, 1'b0, 1'b0);
    for (int i = 0; i <= MEM_TIMEOUT; i++) cycle_check("to_wait", O_FRZ);
    check("to_state", 32'(bus.dbg_state), 2);
    cycle_check("err1", O_ERR);
    set_idle();
    cycle_check("err2", O_ERR);
    drive_mem(1'b1, 1'b0, 1'b1);
    cycle_check("err_ack_ignored", O_ERR);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_outs", 32'(outs), 32'(O_RST));
    check("async_rst_stall", 32'(bus.stall_cycles), 0);
    check("async_rst_state", 32'(bus.dbg_state), 0);
    next_cycle();
    reset     = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    set_idle();
    cycle_check("after_err_run", O_NORM);

    // Saturation of both counters at 7.
    apply_reset();
    drive_hazard(5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle_check("sat_stall", O_LU);
    check("sat_stall_hold", 32'(bus.stall_cycles), 7);
    set_idle();
    bus.ID_BrTaken = 1'b1;
    for (int i = 0; i < 9; i++) cycle_check("sat_flush", O_BR);
    check("sat_flush_hold", 32'(bus.flush_count), 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
